uart_tx_arbiter: RTL and testbench

- Shares the single UART serial transmitter among N_REQ byte producers (e.g. hex/debug reporter, echo path, command responder).
- Selects one pending requester round-robin, latches its byte, and pulses the transmitter start.
- Waits for transmit completion and returns a per-requester done pulse.
- Sits between requester logic and the transmitter's start/busy/done interface.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/rr_select.sv | 51 +++++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared state encoding and default sizing for the UART
//               transmitter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_arb_pkg;

  localparam int c_N_REQ_DEF       = 4;
  localparam int c_DATA_W_DEF      = 8;
  localparam int c_TIMEOUT_CYC_DEF = 65535;

  // Encoding 2'b11 is deliberately left unused.
  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    INICIA = 2'b01,
    ESPERA = 2'b10
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// ============================================================================
// Module      : rr_select
// Description : Combinational requester picker; round-robin from i_ptr, or
//               lowest-index-wins when ARB_FIXED_PRIORITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = c_N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Candidates reordered so bit 0 is the highest-priority slot.
  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_off;

`ifdef ARB_FIXED_PRIORITY_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
  assign w_rot        = i_req;
  assign o_idx        = w_off;
`else
  logic [IDX_W:0] w_sum;
  assign w_rot = N_REQ'({i_req, i_req} >> i_ptr);
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                              : w_sum[IDX_W-1:0];
`endif

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign o_valid = |i_req;
  assign o_pick  = {{(N_REQ-1){1'b0}}, o_valid} << o_idx;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among N_REQ byte producers;
//               ARB_FIXED_PRIORITY_EN selects fixed priority over round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = c_N_REQ_DEF,
  parameter int DATA_W      = c_DATA_W_DEF,
  parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] dados_req,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    erro,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_dados,
  input  logic                    tx_ocupado,
  input  logic                    tx_acabou,
  output logic                    ocupado,
  output logic [1:0]              db_estado
);

  localparam int c_IDX_W = $clog2(N_REQ);
  localparam int c_TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_ptr, w_ptr_nxt, w_ptr_adv;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [N_REQ-1:0]     r_grant, w_grant_nxt, r_done, w_done_nxt, w_idx_hot;
  logic                 r_erro, w_erro_nxt, r_tx_start, w_tx_start_nxt, r_ocupado;
  logic [DATA_W-1:0]    r_tx_dados, w_tx_dados_nxt, w_sel_byte;
  logic [N_REQ-1:0]     w_pick;
  logic [c_IDX_W-1:0]   w_sel_idx;
  logic                 w_sel_valid;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_rr_select (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  always_comb begin
    w_sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_sel_byte = dados_req[i*DATA_W +: DATA_W];
    end
  end

`ifdef ARB_FIXED_PRIORITY_EN
  assign w_ptr_adv = '0;
`else
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);
  assign w_ptr_adv = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
`endif

  assign w_idx_hot = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_idx_nxt      = r_idx;
    w_timer_nxt    = r_timer;
    w_tx_dados_nxt = r_tx_dados;
    w_grant_nxt    = '0;
    w_done_nxt     = '0;
    w_erro_nxt     = 1'b0;
    w_tx_start_nxt = 1'b0;
    case (r_state)
      OCIOSO: begin
        if (w_sel_valid && !tx_ocupado) begin
          w_idx_nxt      = w_sel_idx;
          w_tx_dados_nxt = w_sel_byte;
          w_grant_nxt    = w_pick;
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = INICIA;
        end
      end
      INICIA: begin
        w_timer_nxt = '0;
        w_state_nxt = ESPERA;
      end
      ESPERA: begin
        // Completion takes precedence over a timeout landing on the same edge.
        if (tx_acabou) begin
          w_done_nxt  = w_idx_hot;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = OCIOSO;
        end else if (r_timer == c_TMR_LAST) begin
          w_erro_nxt  = 1'b1;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = OCIOSO;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= OCIOSO;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_erro     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_dados <= '0;
      r_ocupado  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_idx      <= w_idx_nxt;
      r_timer    <= w_timer_nxt;
      r_grant    <= w_grant_nxt;
      r_done     <= w_done_nxt;
      r_erro     <= w_erro_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_dados <= w_tx_dados_nxt;
      r_ocupado  <= (w_state_nxt != OCIOSO);
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign erro      = r_erro;
  assign tx_start  = r_tx_start;
  assign tx_dados  = r_tx_dados;
  assign ocupado   = r_ocupado;
  assign db_estado = r_state;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8,
//               TIMEOUT_CYC=120); honours ARB_FIXED_PRIORITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 120;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] dados_req = '0;
  logic [N-1:0]   grant, done;
  logic           erro, tx_start, ocupado, tx_ocupado;
  logic           tx_acabou = 1'b0;
  logic [W-1:0]   tx_dados;
  logic [1:0]     db_estado;

  logic tx_busy = 1'b0, force_busy = 1'b0, tx_mute = 1'b0;
  int   frame_d = 10, tx_cnt = 0, acabou_cyc = 0;
  int   checks = 0, errors = 0, cyc = 0;
  int   n_grant = 0, n_done = 0, n_erro = 0;
  int   g, gc, dc, ec, t0, nd0, ne0, ng0, t_rst;
  logic [N-1:0] dv;

  assign tx_ocupado = tx_busy | force_busy;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .dados_req(dados_req),
    .grant(grant), .done(done), .erro(erro), .tx_start(tx_start),
    .tx_dados(tx_dados), .tx_ocupado(tx_ocupado), .tx_acabou(tx_acabou),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Transmitter stand-in: tx_acabou is sampled frame_d+1 edges after tx_start.
  always @(negedge clock) begin
    tx_acabou = 1'b0;
    if (tx_start === 1'b1) begin
      if (!tx_mute) begin
        tx_busy = 1'b1;
        tx_cnt  = frame_d;
      end
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy    = 1'b0;
        tx_acabou  = 1'b1;
        acabou_cyc = cyc;
      end
    end
  end

  // Reference model: a transaction is tracked by its age in edges since acceptance.
  logic [N-1:0] exp_grant = '0, exp_done = '0;
  logic         exp_erro = 1'b0, exp_start = 1'b0, exp_ocup = 1'b0;
  logic [W-1:0] exp_dados = '0;
  logic [1:0]   exp_estado = 2'd0;
  bit           m_active = 1'b0;
  int           m_idx = 0, m_ptr = 0, m_age = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (((r >> i) & 1) != 0) return i;
`else
    for (int k = 0; k < N; k++) if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
`endif
    return 0;
  endfunction

  task automatic model_close();
`ifdef ARB_FIXED_PRIORITY_EN
    m_ptr = 0;
`else
    m_ptr = (m_idx + 1) % N;
`endif
    m_active   = 1'b0;
    exp_estado = 2'd0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_grant = '0; exp_done = '0; exp_erro = 1'b0; exp_start = 1'b0;
      exp_dados = '0; exp_ocup = 1'b0; exp_estado = 2'd0;
      m_active = 1'b0; m_ptr = 0;
    end else begin
      exp_grant = '0; exp_done = '0; exp_erro = 1'b0; exp_start = 1'b0;
      if (!m_active) begin
        if (req != 0 && !tx_ocupado) begin
          m_idx      = pick(req, m_ptr);
          m_active   = 1'b1;
          m_age      = 0;
          exp_grant  = {{(N-1){1'b0}}, 1'b1} << m_idx;
          exp_start  = 1'b1;
          exp_dados  = dados_req[m_idx*W +: W];
          exp_estado = 2'd1;
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          exp_estado = 2'd2;
        end else if (tx_acabou) begin
          exp_done = {{(N-1){1'b0}}, 1'b1} << m_idx;
          model_close();
        end else if (m_age == TMO + 1) begin
          exp_erro = 1'b1;
          model_close();
        end
      end
      exp_ocup = m_active;
    end
  end

  always @(negedge clock) begin
    check("grant", grant, exp_grant);
    check("done", done, exp_done);
    check("erro", erro, exp_erro);
    check("tx_start", tx_start, exp_start);
    check("tx_dados", tx_dados, exp_dados);
    check("ocupado", ocupado, exp_ocup);
    check("db_estado", db_estado, exp_estado);
    check("estado_legal", db_estado == 2'b11, 0);
    if (grant != 0) n_grant++;
    if (done != 0)  n_done++;
    if (erro)       n_erro++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_grant(input int maxc, output int gidx, output int gcyc);
    gidx = -1; gcyc = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (grant != 0) begin
        gidx = $clog2(grant);
        gcyc = cyc;
        break;
      end
    end
    if (gidx < 0) begin
      checks++; errors++;
      $display("FAIL wait_grant: none within %0d cycles", maxc);
    end
  endtask

  task automatic wait_done(input int maxc, output int dcyc, output logic [N-1:0] dval);
    dcyc = -1; dval = '0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (done != 0) begin
        dcyc = cyc;
        dval = done;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++; errors++;
      $display("FAIL wait_done: none within %0d cycles", maxc);
    end
  endtask

  task automatic wait_erro(input int maxc, output int ecyc);
    ecyc = -1;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (erro) begin
        ecyc = cyc;
        break;
      end
    end
    if (ecyc < 0) begin
      checks++; errors++;
      $display("FAIL wait_erro: none within %0d cycles", maxc);
    end
  endtask

  task automatic wait_idle(input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      step();
      if (!ocupado) break;
    end
    if (i == maxc) begin
      checks++; errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", maxc);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ARB_FIXED_PRIORITY_EN
    int ord[5] = '{0, 0, 0, 0, 0};
    int t3_exp = 0;
`else
    int ord[5] = '{0, 1, 2, 3, 0};
    int t3_exp = 3;
`endif
    step(3);
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_dados", tx_dados, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_estado", db_estado, 0);
    reset_n = 1'b1;
    step(2);

    // Single requester, 100-cycle frame.
    frame_d   = 99;
    dados_req = 32'h0041_0000;
    req       = 4'b0100;
    t0        = cyc;
    wait_grant(10, g, gc);
    check("t1_idx", g, 2);
    check("t1_latency", gc - t0, 1);
    check("t1_tx_start", tx_start, 1);
    check("t1_tx_dados", tx_dados, 8'h41);
    req = '0;
    wait_done(200, dc, dv);
    check("t1_done", dv, 4'b0100);
    check("t1_done_after_acabou", dc - acabou_cyc, 1);
    check("t1_frame", dc - gc, 100);
    step(2);

    // All four requesting with distinct bytes.
    do_reset();
    frame_d   = 10;
    dados_req = 32'hA3A2_A1A0;
    req       = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_grant(40, g, gc);
      check("t2_order", g, ord[t]);
      check("t2_byte", tx_dados, 8'hA0 + ord[t]);
      check("t2_onehot", $countones(grant), 1);
      if (t == 4) req = '0;
    end
    wait_idle(40);

    // ptr now 1: requester 3 ahead of 0 unless fixed priority.
    req = 4'b1001;
    wait_grant(10, g, gc);
    check("t3_first", g, t3_exp);
    req = '0;
    wait_idle(40);
    req = 4'b0011;
    wait_grant(10, g, gc);
    check("t3_wrap", g, 0);
    req = '0;
    wait_idle(40);

    // Timeout with a silent transmitter.
    tx_mute = 1'b1;
    nd0     = n_done;
    req     = 4'b0010;
    wait_grant(10, g, gc);
    check("t4_idx", g, 1);
    req = '0;
    wait_erro(200, ec);
    check("t4_erro_latency", ec - gc, 121);
    step(2);
    check("t4_no_done", n_done, nd0);
    check("t4_idle", ocupado, 0);
    tx_mute = 1'b0;
    req     = 4'b0001;
    wait_grant(10, g, gc);
    check("t4_next_served", g, 0);
    req = '0;
    wait_idle(40);

    // Completion on the timeout edge: done wins.
    frame_d = 120;
    ne0     = n_erro;
    req     = 4'b0100;
    wait_grant(10, g, gc);
    req = '0;
    wait_done(200, dc, dv);
    check("t5_done", dv, 4'b0100);
    check("t5_on_timeout_edge", dc - gc, 121);
    step(3);
    check("t5_no_erro", n_erro, ne0);
    frame_d = 10;

    // Transmitter busy blocks the grant; withdrawn request is never served.
    force_busy = 1'b1;
    ng0        = n_grant;
    req        = 4'b0010;
    step(6);
    check("t6_blocked", n_grant, ng0);
    force_busy = 1'b0;
    t0         = cyc;
    wait_grant(10, g, gc);
    check("t6_idx", g, 1);
    check("t6_latency", gc - t0, 1);
    req = '0;
    wait_idle(40);
    force_busy = 1'b1;
    ng0        = n_grant;
    req        = 4'b1000;
    step(4);
    req        = '0;
    force_busy = 1'b0;
    step(6);
    check("t6_withdrawn", n_grant, ng0);

    // Reset during the wait phase; the late tx_acabou must be ignored.
    frame_d = 30;
    req     = 4'b0100;
    wait_grant(10, g, gc);
    req = '0;
    step(5);
    check("t7_in_espera", db_estado, 2'b10);
    #2 reset_n = 1'b0;
    t_rst = cyc;
    #1;
    check("t7_grant", grant, 0);
    check("t7_done", done, 0);
    check("t7_erro", erro, 0);
    check("t7_tx_start", tx_start, 0);
    check("t7_tx_dados", tx_dados, 0);
    check("t7_ocupado", ocupado, 0);
    check("t7_estado", db_estado, 0);
    step(2);
    reset_n = 1'b1;
    nd0 = n_done;
    ne0 = n_erro;
    step(40);
    check("t7_late_acabou_seen", acabou_cyc > t_rst, 1);
    check("t7_no_done", n_done, nd0);
    check("t7_no_erro", n_erro, ne0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
